// File: rtl/dmem_block_mover_pkg.sv
// Shared definitions for the block copy/fill engine: FSM encoding, mode values
// and the default word stride / transfer limit.
package dmem_block_mover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int unsigned ADDR_STEP = 2;
  localparam int unsigned MAX_WORDS = 128;

endpackage

// File: rtl/dmem_block_mover.sv
// Bus-initiator engine that copies N words src->dst or fills N words at dst,
// owning the data-memory port while busy.
module dmem_block_mover #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned MAX_WORDS = dmem_block_mover_pkg::MAX_WORDS,
  parameter int unsigned ADDR_STEP = dmem_block_mover_pkg::ADDR_STEP
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [DATA_W-1:0]  fill_value,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_write,
  output logic               mem_read,
  output logic               busy,
  output logic               done
);

  import dmem_block_mover_pkg::*;

  localparam logic [ADDR_W-1:0]  STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0]  WORD_MASK = ~ADDR_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = COUNT_W'(MAX_WORDS);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  src_reg, dst_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic               mode_reg;
  logic [DATA_W-1:0]  fill_reg, hold_reg;

  logic [COUNT_W-1:0] count_sat;
  logic               last_word;

  assign count_sat = (word_count > CNT_MAX) ? CNT_MAX : word_count;
  assign last_word = (cnt_reg == COUNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (count_sat == '0)          state_next = ST_FINISH;
          else if (mode == MODE_FILL)   state_next = ST_WRITE;
          else                          state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_WRITE;
      ST_WRITE: begin
        if (last_word)                  state_next = ST_FINISH;
        else if (mode_reg == MODE_FILL) state_next = ST_WRITE;
        else                            state_next = ST_READ;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Transfer parameters are captured once at start; the pointers hold
  // word-aligned addresses and wrap modulo 2**ADDR_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      cnt_reg  <= '0;
      mode_reg <= MODE_COPY;
      fill_reg <= '0;
      hold_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            src_reg  <= src_addr & WORD_MASK;
            dst_reg  <= dst_addr & WORD_MASK;
            cnt_reg  <= count_sat;
            mode_reg <= mode;
            fill_reg <= fill_value;
          end
        end
        ST_READ: begin
          hold_reg <= mem_rdata;
          src_reg  <= src_reg + STEP;
        end
        ST_WRITE: begin
          dst_reg <= dst_reg + STEP;
          cnt_reg <= cnt_reg - COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      ST_READ: begin
        mem_addr = src_reg;
        mem_read = 1'b1;
        busy     = 1'b1;
      end
      ST_WRITE: begin
        mem_addr  = dst_reg;
        mem_wdata = (mode_reg == MODE_FILL) ? fill_reg : hold_reg;
        mem_write = 1'b1;
        busy      = 1'b1;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Randomised scoreboard bench for dmem_block_mover: a word-level memory model
// predicts every bus transaction and the done pulse with its exact cycle.
module tb_dmem_block_mover;

  localparam logic [15:0] SW_ADDR   = 16'hFFF0;
  localparam logic [15:0] DISP_ADDR = 16'hFFFA;
  localparam logic [15:0] SW_VAL    = 16'h3C5A;
  localparam int          NO_LIMIT  = 1 << 30;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  word_count;
  logic [15:0] fill_value;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_write, mem_read, busy, done;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [6:0]  io_display;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } txn_t;
  txn_t exp_q[$];

  dmem_block_mover dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .fill_value(fill_value), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign mem_rdata = (mem_addr == SW_ADDR) ? SW_VAL : mem[mem_addr[15:1]];

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] pack(input int kind, input logic [15:0] addr,
                                       input logic [15:0] data, input int c);
    return {8'(kind), addr, data, 24'(c)};
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return (a == SW_ADDR) ? SW_VAL : ref_mem[a[15:1]];
  endfunction

  // Reference: word i of a copy is read in cycle 2i+1 and written in 2i+2;
  // fill writes word i in cycle i+1; done follows the last bus cycle.
  task automatic model_op(input bit m, input logic [15:0] src, input logic [15:0] dst,
                          input int cnt, input logic [15:0] fill, input int base,
                          input int limit);
    int n;
    int c;
    logic [15:0] s, d, v;
    n = (cnt > 128) ? 128 : cnt;
    s = src & 16'hFFFE;
    d = dst & 16'hFFFE;
    for (int i = 0; i < n; i++) begin
      if (m == 1'b0) begin
        c = 2 * i + 1;
        if (c <= limit) exp_q.push_back('{0, s, 16'h0, base + c});
        v = ref_read(s);
        s = s + 16'd2;
        c = 2 * i + 2;
      end else begin
        v = fill;
        c = i + 1;
      end
      if (c <= limit) begin
        ref_mem[d[15:1]] = v;
        exp_q.push_back('{1, d, v, base + c});
      end
      d = d + 16'd2;
    end
    c = ((m == 1'b0) ? 2 * n : n) + 1;
    if (c <= limit) exp_q.push_back('{2, 16'h0, 16'h0, base + c});
  endtask

  // Called at posedge+1; the following posedge samples start.
  task automatic issue(input bit m, input logic [15:0] src, input logic [15:0] dst,
                       input int cnt, input logic [15:0] fill, input int limit);
    model_op(m, src, dst, cnt, fill, cyc, limit);
    mode = m; src_addr = src; dst_addr = dst; word_count = 8'(cnt); fill_value = fill;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
    word_count = 8'($urandom); fill_value = 16'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  initial begin
    fork
      forever begin : monitor
        int          ok_kind;
        logic [15:0] od;
        txn_t        e;
        @(negedge clock);
        if (!reset_n) begin
          check({mem_addr, mem_wdata, mem_write, mem_read, busy, done} == '0,
                "reset_outputs", 64'({mem_addr, mem_wdata, mem_write, mem_read, busy, done}), 64'd0);
        end else begin
          check(!(mem_read && mem_write) && (busy == (mem_read || mem_write)),
                "bus_strobes", 64'({mem_read, mem_write, busy}), 64'({1'b0, 1'b0, busy}));
          if (!busy)
            check({mem_addr, mem_wdata} == '0, "idle_bus_zero", 64'({mem_addr, mem_wdata}), 64'd0);
          if (mem_write) begin
            mem[mem_addr[15:1]] = mem_wdata;
            if (mem_addr == DISP_ADDR) io_display = mem_wdata[6:0];
          end
          ok_kind = done ? 2 : (mem_write ? 1 : (mem_read ? 0 : -1));
          if (ok_kind >= 0) begin
            od = mem_write ? mem_wdata : 16'h0;
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_txn", pack(ok_kind, mem_addr, od, cyc), 64'd0);
            end else begin
              e = exp_q.pop_front();
              check(pack(ok_kind, mem_addr, od, cyc) == pack(e.kind, e.addr, e.data, e.cyc),
                    "bus_txn", pack(ok_kind, mem_addr, od, cyc),
                    pack(e.kind, e.addr, e.data, e.cyc));
            end
          end
        end
      end
    join_none

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    word_count = '0; fill_value = '0; io_display = '0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8] = 16'h00A1; mem[9] = 16'h00B2; mem[10] = 16'h00C3;
    ref_mem[8] = 16'h00A1; ref_mem[9] = 16'h00B2; ref_mem[10] = 16'h00C3;

    repeat (3) @(posedge clock);
    #1;
    check({mem_addr, mem_wdata, mem_write, mem_read, busy, done} == '0, "reset_state",
          64'({mem_addr, mem_wdata, mem_write, mem_read, busy, done}), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // copy 3 words 0x10 -> 0x40: done expected in cycle 7
    issue(1'b0, 16'h0010, 16'h0040, 3, 16'h0, NO_LIMIT);
    drain(50);
    check({mem[16'h20], mem[16'h21], mem[16'h22]} == {16'h00A1, 16'h00B2, 16'h00C3},
          "copy_result", 64'({mem[16'h20], mem[16'h21], mem[16'h22]}), 64'h00A1_00B2_00C3);

    // fill 4 words of BEEF at 0x80
    issue(1'b1, 16'h0080, 16'h0080, 4, 16'hBEEF, NO_LIMIT);
    drain(50);
    check({mem[16'h40], mem[16'h43]} == {16'hBEEF, 16'hBEEF}, "fill_result",
          64'({mem[16'h40], mem[16'h43]}), 64'hBEEF_BEEF);

    // zero-length request: done in cycle 1, no bus activity
    issue(1'b0, 16'h0100, 16'h0200, 0, 16'h0, NO_LIMIT);
    drain(10);

    // IO display write and address wrap on copy
    issue(1'b1, 16'h0, DISP_ADDR, 1, 16'h005B, NO_LIMIT);
    drain(10);
    check(io_display == 7'h5B, "io_display", 64'(io_display), 64'h5B);
    issue(1'b0, 16'hFFFE, 16'h0600, 2, 16'h0, NO_LIMIT);
    drain(20);
    issue(1'b0, SW_ADDR, 16'h0700, 1, 16'h0, NO_LIMIT);
    drain(20);
    check(mem[16'h0380] == SW_VAL, "switch_copy", 64'(mem[16'h0380]), 64'(SW_VAL));

    // reset in cycle 3 of a 5-word copy: only word 0 lands, no done
    issue(1'b0, 16'h0300, 16'h0400, 5, 16'h0, 2);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check({mem_addr, mem_wdata, mem_write, mem_read, busy, done} == '0, "reset_abort",
          64'({mem_addr, mem_wdata, mem_write, mem_read, busy, done}), 64'd0);
    check(exp_q.size() == 0, "reset_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    issue(1'b0, 16'h0300, 16'h0500, 3, 16'h0, NO_LIMIT);
    drain(50);

    // saturated count with a stray start while busy
    issue(1'b0, 16'h1000, 16'h3000, 200, 16'h0, NO_LIMIT);
    repeat (10) begin @(posedge clock); #1; end
    mode = 1'b1; dst_addr = 16'h5000; word_count = 8'd9; fill_value = 16'hDEAD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    drain(600);

    for (int t = 0; t < 24; t++) begin
      bit          m;
      logic [15:0] s, d, f;
      int          n;
      m = 1'($urandom);
      s = 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? s + 16'($urandom_range(0, 8)) : 16'($urandom);
      f = 16'($urandom);
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(129, 255)) : int'($urandom_range(0, 24));
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      issue(m, s, d, n, f, NO_LIMIT);
      drain(700);
    end

    begin
      int bad;
      bad = -1;
      for (int i = 0; i < 32768; i++)
        if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
      check(bad < 0, "memory_image", (bad < 0) ? 64'd0 : 64'({16'(bad), mem[bad]}),
            (bad < 0) ? 64'd0 : 64'({16'(bad), ref_mem[bad]}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
